// File: rtl/ir_transport_ctrl.sv
// ir_transport_ctrl
//   Transport-state controller for the IR remote player. Accepts decoded IR
//   command frames, sequences STOPPED/PLAYING/PAUSED, tracks the current track
//   index and elapsed seconds, and drives the four active-low board LEDs.
//
// Ports
//   clock      in   system clock, all logic on posedge
//   reset      in   synchronous, active-high
//   cmd_valid  in   one-cycle strobe qualifying cmd_code / cmd_repeat
//   cmd_code   in   decoded IR command byte
//   cmd_repeat in   frame is an NEC repeat frame (never acts)
//   cmd_ack    out  registered one-cycle pulse per accepted command
//   state      out  00 STOPPED, 01 PLAYING, 10 PAUSED
//   track      out  current track index
//   seconds    out  elapsed seconds in current track
//   saida      out  active-low LEDs: [1] stopped, [2] playing, [3] paused, [4] lockout
module ir_transport_ctrl #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned REPEAT_HOLD = 5000000,
  parameter int unsigned NUM_TRACKS  = 8,
  parameter int unsigned TRACK_LEN   = 180,
  parameter logic [7:0]  CMD_PLAY    = 8'h01,
  parameter logic [7:0]  CMD_NEXT    = 8'h02,
  parameter logic [7:0]  CMD_STOP    = 8'h03,
  parameter logic [7:0]  CMD_PREV    = 8'h04
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cmd_valid,
  input  logic [7:0]                    cmd_code,
  input  logic                          cmd_repeat,
  output logic                          cmd_ack,
  output logic [1:0]                    state,
  output logic [$clog2(NUM_TRACKS)-1:0] track,
  output logic [7:0]                    seconds,
  output logic [4:1]                    saida
);

  localparam int unsigned TrackW = $clog2(NUM_TRACKS);
  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned LockW  = (REPEAT_HOLD > 0) ? $clog2(REPEAT_HOLD + 1) : 1;

  localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_DIV - 1);
  localparam logic [TrackW-1:0] TrackLast = TrackW'(NUM_TRACKS - 1);
  localparam logic [7:0]        SecLast   = 8'(TRACK_LEN - 1);
  localparam logic [LockW-1:0]  LockLoad  = LockW'(REPEAT_HOLD);

  typedef enum logic [1:0] {
    StStopped = 2'b00,
    StPlaying = 2'b01,
    StPaused  = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [TrackW-1:0]   track_q, track_d;
  logic [7:0]          seconds_q, seconds_d;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic [LockW-1:0]    lock_q, lock_d;
  logic                ack_q, ack_d;
  logic [4:1]          saida_q, saida_d;

  logic                known_code;
  logic                accept;
  logic                tick;

  always_comb begin
    known_code = (cmd_code == CMD_PLAY) || (cmd_code == CMD_NEXT) ||
                 (cmd_code == CMD_STOP) || (cmd_code == CMD_PREV);
    accept     = cmd_valid && !cmd_repeat && (lock_q == '0) && known_code;
    tick       = (state_q == StPlaying) && (presc_q == PrescLast);
  end

  always_comb begin
    state_d   = state_q;
    track_d   = track_q;
    seconds_d = seconds_q;
    presc_d   = presc_q;
    lock_d    = (lock_q != '0) ? lock_q - 1'b1 : '0;
    ack_d     = 1'b0;

    // Prescaler runs only while playing; a tick wraps it back to zero.
    unique case (state_q)
      StPlaying: presc_d = tick ? '0 : presc_q + 1'b1;
      StPaused:  presc_d = presc_q;
      default:   presc_d = '0;
    endcase

    if (accept) begin
      // An accepted command takes priority; a coincident tick is dropped.
      lock_d = LockLoad;
      ack_d  = 1'b1;
      if (cmd_code == CMD_PLAY) begin
        state_d = (state_q == StPlaying) ? StPaused : StPlaying;
      end else if (cmd_code == CMD_STOP) begin
        state_d   = StStopped;
        seconds_d = '0;
        presc_d   = '0;
      end else if (cmd_code == CMD_NEXT) begin
        track_d   = track_q + 1'b1;  // power-of-two track count wraps naturally
        seconds_d = '0;
        presc_d   = '0;
      end else begin
        // PREV restarts the current track once a few seconds have played.
        if (seconds_q < 8'd3) begin
          track_d = track_q - 1'b1;
        end
        seconds_d = '0;
        presc_d   = '0;
      end
    end else if (tick) begin
      if (seconds_q != SecLast) begin
        seconds_d = seconds_q + 8'd1;
      end else if (track_q != TrackLast) begin
        seconds_d = '0;
        track_d   = track_q + 1'b1;
      end else begin
        seconds_d = '0;
        track_d   = '0;
        state_d   = StStopped;
      end
    end

    // LEDs are registered from next-state so they line up with the state register.
    saida_d = {~(lock_d != '0), ~(state_d == StPaused), ~(state_d == StPlaying),
               ~(state_d == StStopped)};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StStopped;
      track_q   <= '0;
      seconds_q <= '0;
      presc_q   <= '0;
      lock_q    <= '0;
      ack_q     <= 1'b0;
      saida_q   <= 4'b1110;
    end else begin
      state_q   <= state_d;
      track_q   <= track_d;
      seconds_q <= seconds_d;
      presc_q   <= presc_d;
      lock_q    <= lock_d;
      ack_q     <= ack_d;
      saida_q   <= saida_d;
    end
  end

  assign cmd_ack = ack_q;
  assign state   = state_q;
  assign track   = track_q;
  assign seconds = seconds_q;
  assign saida   = saida_q;

endmodule

// File: tb/tb_ir_transport_ctrl.sv
module tb_ir_transport_ctrl;

  localparam logic [7:0] PLAY = 8'h01;
  localparam logic [7:0] NEXT = 8'h02;
  localparam logic [7:0] STOP = 8'h03;
  localparam logic [7:0] PREV = 8'h04;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic       cmd_repeat;
  logic       cmd_ack;
  logic [1:0] state;
  logic [1:0] track;
  logic [7:0] seconds;
  logic [4:1] saida;

  int n_cmp = 0;
  int n_err = 0;

  ir_transport_ctrl #(
    .TICK_DIV    (4),
    .REPEAT_HOLD (3),
    .NUM_TRACKS  (4),
    .TRACK_LEN   (5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_repeat (cmd_repeat),
    .cmd_ack    (cmd_ack),
    .state      (state),
    .track      (track),
    .seconds    (seconds),
    .saida      (saida)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] code;
    logic       rpt;
    logic [1:0] st;
    logic [1:0] trk;
    logic [7:0] sec;
    logic       ack;
    logic [3:0] led;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] code, input logic rpt);
    cmd_valid  = 1'b1;
    cmd_code   = code;
    cmd_repeat = rpt;
    clk(1);
    cmd_valid  = 1'b0;
    cmd_code   = 8'h00;
    cmd_repeat = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clk(1);
    reset = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic [1:0] trk,
                         input logic [7:0] sec, input logic ack, input logic [3:0] led);
    chk({tag, ".state"},   32'(state),   32'(st));
    chk({tag, ".track"},   32'(track),   32'(trk));
    chk({tag, ".seconds"}, 32'(seconds), 32'(sec));
    chk({tag, ".ack"},     32'(cmd_ack), 32'(ack));
    chk({tag, ".saida"},   32'(saida),   32'(led));
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_code   = 8'h00;
    cmd_repeat = 1'b0;

    // One row per clock: inputs applied, outputs expected after that edge.
    //              rst   vld   code   rpt   st     trk   sec   ack   saida[4:1]
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 4'b1110};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 4'b1110};
    vecs[2]  = '{1'b0, 1'b1, PLAY,  1'b0, 2'd1, 2'd0, 8'd0, 1'b1, 4'b0101};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd1, 2'd0, 8'd0, 1'b0, 4'b0101};
    vecs[4]  = '{1'b0, 1'b1, PLAY,  1'b0, 2'd1, 2'd0, 8'd0, 1'b0, 4'b0101};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd1, 2'd0, 8'd0, 1'b0, 4'b1101};
    vecs[6]  = '{1'b0, 1'b1, PLAY,  1'b1, 2'd1, 2'd0, 8'd1, 1'b0, 4'b1101};
    vecs[7]  = '{1'b0, 1'b1, 8'h55, 1'b0, 2'd1, 2'd0, 8'd1, 1'b0, 4'b1101};
    vecs[8]  = '{1'b0, 1'b1, NEXT,  1'b0, 2'd1, 2'd1, 8'd0, 1'b1, 4'b0101};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd1, 2'd1, 8'd0, 1'b0, 4'b0101};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd1, 2'd1, 8'd0, 1'b0, 4'b0101};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd1, 2'd1, 8'd0, 1'b0, 4'b1101};
    vecs[12] = '{1'b0, 1'b1, STOP,  1'b0, 2'd0, 2'd1, 8'd0, 1'b1, 4'b0110};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd1, 8'd0, 1'b0, 4'b0110};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd1, 8'd0, 1'b0, 4'b0110};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd1, 8'd0, 1'b0, 4'b1110};
    vecs[16] = '{1'b0, 1'b1, STOP,  1'b0, 2'd0, 2'd1, 8'd0, 1'b1, 4'b0110};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd1, 8'd0, 1'b0, 4'b0110};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd1, 8'd0, 1'b0, 4'b0110};
    vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd1, 8'd0, 1'b0, 4'b1110};
    vecs[20] = '{1'b0, 1'b1, PREV,  1'b0, 2'd0, 2'd0, 8'd0, 1'b1, 4'b0110};
    vecs[21] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 4'b0110};
    vecs[22] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 4'b0110};
    vecs[23] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 4'b1110};
    vecs[24] = '{1'b0, 1'b1, PREV,  1'b0, 2'd0, 2'd3, 8'd0, 1'b1, 4'b0110};
    vecs[25] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2'd3, 8'd0, 1'b0, 4'b0110};

    for (int i = 0; i < 26; i++) begin
      reset      = vecs[i].rst;
      cmd_valid  = vecs[i].vld;
      cmd_code   = vecs[i].code;
      cmd_repeat = vecs[i].rpt;
      clk(1);
      chk_all($sformatf("v%0d", i), vecs[i].st, vecs[i].trk, vecs[i].sec, vecs[i].ack,
              vecs[i].led);
    end
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_code   = 8'h00;
    cmd_repeat = 1'b0;

    // Play for three seconds, pause, and confirm time freezes.
    do_reset();
    send(PLAY, 1'b0);
    clk(12);
    chk("pause.sec_before", 32'(seconds), 32'd3);
    send(PLAY, 1'b0);
    chk_all("pause.enter", 2'd2, 2'd0, 8'd3, 1'b1, 4'b0011);
    clk(11);
    chk_all("pause.hold", 2'd2, 2'd0, 8'd3, 1'b0, 4'b1011);

    // End of last track stops and rewinds to track 0.
    do_reset();
    repeat (3) begin
      send(NEXT, 1'b0);
      clk(3);
    end
    chk("eot.track3", 32'(track), 32'd3);
    send(PLAY, 1'b0);
    clk(16);
    chk_all("eot.last_sec", 2'd1, 2'd3, 8'd4, 1'b0, 4'b1101);
    clk(4);
    chk_all("eot.stop", 2'd0, 2'd0, 8'd0, 1'b0, 4'b1110);

    // End of a middle track auto-advances and keeps playing.
    send(NEXT, 1'b0);
    clk(3);
    send(PLAY, 1'b0);
    clk(16);
    chk_all("adv.last_sec", 2'd1, 2'd1, 8'd4, 1'b0, 4'b1101);
    clk(4);
    chk_all("adv.next", 2'd1, 2'd2, 8'd0, 1'b0, 4'b1101);

    // PREV wraps below track 0 early in a track, restarts later in a track.
    send(STOP, 1'b0);
    clk(3);
    send(NEXT, 1'b0);
    clk(3);
    send(NEXT, 1'b0);
    clk(3);
    send(PLAY, 1'b0);
    clk(4);
    chk("prev.pre_track", 32'(track), 32'd0);
    chk("prev.pre_sec", 32'(seconds), 32'd1);
    send(PREV, 1'b0);
    chk_all("prev.wrap", 2'd1, 2'd3, 8'd0, 1'b1, 4'b0101);
    clk(12);
    chk("prev.sec3", 32'(seconds), 32'd3);
    send(PREV, 1'b0);
    chk_all("prev.restart", 2'd1, 2'd3, 8'd0, 1'b1, 4'b0101);

    // Reset while playing with lockout active and prescaler at its last count.
    do_reset();
    send(PLAY, 1'b0);
    clk(6);
    send(PLAY, 1'b0);
    chk_all("rst.paused", 2'd2, 2'd0, 8'd1, 1'b1, 4'b0011);
    clk(3);
    send(PLAY, 1'b0);
    chk_all("rst.resumed", 2'd1, 2'd0, 8'd1, 1'b1, 4'b0101);
    reset = 1'b1;
    clk(1);
    reset = 1'b0;
    chk_all("rst.applied", 2'd0, 2'd0, 8'd0, 1'b0, 4'b1110);
    clk(1);
    chk_all("rst.after", 2'd0, 2'd0, 8'd0, 1'b0, 4'b1110);

    // STOP landing on a tick edge wins over the tick.
    send(PLAY, 1'b0);
    clk(7);
    chk("stoptick.pre_sec", 32'(seconds), 32'd1);
    send(STOP, 1'b0);
    chk_all("stoptick", 2'd0, 2'd0, 8'd0, 1'b1, 4'b0110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
